health_bar_controller: RTL and testbench
========================================

// Module: health_bar_controller
// PURPOSE
//  Owns player hit points and sequences the health-bar sprite ROM for the VGA renderer.
//  - Applies damage and heal events from game logic.
//  - Animates the displayed level toward the true level, one step per DRAIN_FRAMES frames.
//  - Generates ROM image select and address from the pixel scan position.
//  - Returns a bar pixel aligned to the ROM's 1-cycle registered read.
//  Sits between game_logic and the health-bar ROM. Its bar_pixel feeds the VGA colour mux.
// PARAMETERS
//  MAX_HP        16   full health; ROM holds images for levels 1..16 (image index = level-1)
//  BAR_X         16   left pixel column of the bar window
//  BAR_Y         8    top pixel row of the bar window
//  BAR_W         16   bar width in pixels; BAR_W*BAR_H must be <= 128
//  BAR_H         8    bar height in pixels
//  DRAIN_FRAMES  4    frames per one-step change of the displayed level
//  FLASH_FRAMES  32   frames of blink after a hit (HEALTH_FLASH_EN only)
// PORTS
//  clk          in   1   system/pixel clock; only clock
//  rst_n        in   1   asynchronous, active-low reset
//  frame_start  in   1   1-cycle pulse per frame, issued in vertical blank
//  game_reset   in   1   synchronous restart to full health
//  dmg_valid    in   1   damage event strobe
//  dmg_amt      in   4   damage amount
//  heal_valid   in   1   heal event strobe
//  heal_amt     in   4   heal amount
//  pixel_x      in   10  current scan column
//  pixel_y      in   10  current scan row
//  mem_health   out  4   ROM image select = shown-1 (0 when shown==0)
//  mem_address  out  8   ROM address, registered
//  mem_pixel    in   1   ROM read data; arrives 1 cycle after mem_address
//  bar_pixel    out  1   bar foreground pixel; valid 2 cycles after pixel_x/pixel_y
//  bar_active   out  1   scan position inside bar window, aligned with bar_pixel
//  hp_level     out  5   true health, 0..MAX_HP
//  hp_shown     out  5   displayed (animated) health
//  dead         out  1   high while hp_level==0
//  dead_pulse   out  1   1-cycle pulse when hp_level goes nonzero -> 0
// BEHAVIOUR
//  Reset (async) and game_reset (sync) values:
//   - hp_level = hp_shown = MAX_HP; FSM IDLE; frame and flash counters 0.
//   - mem_health = MAX_HP-1; mem_address, bar_pixel, bar_active, dead, dead_pulse = 0.
//   - game_reset overrides any event in the same cycle.
//  Health update:
//   - Takes effect next cycle: hp' = hp - (dmg_valid?dmg_amt:0) + (heal_valid?heal_amt:0).
//   - Computed as 7-bit signed; saturated to [0, MAX_HP].
//   - While dead, heal is ignored; damage is a no-op. Only game_reset revives.
//  Display FSM (evaluated every cycle):
//   - IDLE:  hp_shown==hp_level.
//   - DRAIN: hp_shown>hp_level.
//   - FILL:  hp_shown<hp_level.
//   - In DRAIN/FILL, frame_cnt increments on frame_start.
//   - When frame_cnt==DRAIN_FRAMES-1 at a frame_start: hp_shown steps by 1 toward hp_level,
//     frame_cnt clears.
//   - Entering IDLE clears frame_cnt.
//   - A target change mid-animation redirects without resetting frame_cnt.
//   - hp_shown changes only on frame_start, so the image never tears mid-frame.
//  Pixel pipeline:
//   - Stage 1 (registered):
//     in_win = pixel_x in [BAR_X, BAR_X+BAR_W) and pixel_y in [BAR_Y, BAR_Y+BAR_H).
//     mem_address = (y-BAR_Y)*BAR_W + (x-BAR_X), truncated to 8 bits; 0 when outside window.
//   - Stage 2: bar_active = in_win delayed; bar_pixel = bar_active & mem_pixel & (hp_shown!=0).
//   - Total latency: 2 cycles from pixel_x/pixel_y.
//  dead / dead_pulse track hp_level, not hp_shown.
// CONFIGURATION
//  HEALTH_FLASH_EN defined:
//   - Damage with dmg_amt!=0 while alive loads flash_cnt = FLASH_FRAMES.
//   - flash_cnt decrements on frame_start while nonzero.
//   - While flash_cnt!=0 and flash_cnt[2]==1, bar_pixel is forced 0 (4-frame blink).
//   - flash_cnt resets to 0 on reset and game_reset.
//  HEALTH_FLASH_EN undefined: no flash counter; bar_pixel is per BEHAVIOUR only.
// TESTING
//  1 Release rst_n -> hp_level=16, hp_shown=16, mem_health=15, dead=0, bar_pixel=0.
//  2 dmg 3 at hp 16 -> hp_level=13 next cycle; FSM DRAIN; hp_shown 15,14,13 at frame_starts
//    4,8,12; then IDLE.
//  3 dmg 5 + heal 2 same cycle at hp 10 -> hp_level 7.
//    Then dmg 15 at hp 4 -> hp_level 0, dead_pulse exactly 1 cycle; later heal 5 -> stays 0.
//  4 pixel (BAR_X+3, BAR_Y+2) -> mem_address 35 after 1 cycle; bar_pixel = mem_pixel after 2 cycles.
//    pixel (BAR_X+16, BAR_Y) -> bar_active 0.
//  5 game_reset with dmg 8 same cycle -> hp_level = hp_shown = 16, IDLE.
//    Async rst_n mid-DRAIN -> all reset values.
//  6 HEALTH_FLASH_EN: dmg 1 -> bar_pixel masked in frames where flash_cnt[2]=1, clear after 32 frames.
//    Macro off -> never masked.

Source files
------------

// File: rtl/health_bar_controller.sv
// Health-bar controller: owns hit points, animates the displayed level and drives the bar sprite ROM.
// Optional hit-blink masking of bar_pixel is enabled by defining HEALTH_FLASH_EN.
module health_bar_controller #(
    parameter int unsigned MAX_HP       = 16,
    parameter int unsigned BAR_X        = 16,
    parameter int unsigned BAR_Y        = 8,
    parameter int unsigned BAR_W        = 16,
    parameter int unsigned BAR_H        = 8,
    parameter int unsigned DRAIN_FRAMES = 4,
    parameter int unsigned FLASH_FRAMES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       game_reset,
    input  logic       dmg_valid,
    input  logic [3:0] dmg_amt,
    input  logic       heal_valid,
    input  logic [3:0] heal_amt,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic [3:0] mem_health,
    output logic [7:0] mem_address,
    input  logic       mem_pixel,
    output logic       bar_pixel,
    output logic       bar_active,
    output logic [4:0] hp_level,
    output logic [4:0] hp_shown,
    output logic       dead,
    output logic       dead_pulse
);

    localparam int unsigned HP_W   = 5;
    localparam int unsigned FCNT_W = (DRAIN_FRAMES > 1) ? $clog2(DRAIN_FRAMES) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;

    logic [1:0]        state, state_next;
    logic [FCNT_W-1:0] frame_cnt, frame_cnt_next;
    logic [HP_W-1:0]   level_next, shown_next;
    logic [3:0]        mem_health_next;
    logic              dead_next, dead_pulse_next;
    logic signed [6:0] dmg_term, heal_term, hp_sum;
    logic              in_win;
    logic [9:0]        dx, dy;
    logic              flash_mask;

    // Health arithmetic, display animation and derived status, all evaluated every cycle.
    always_comb begin
        dmg_term        = dmg_valid  ? $signed({3'b000, dmg_amt})  : 7'sd0;
        heal_term       = heal_valid ? $signed({3'b000, heal_amt}) : 7'sd0;
        hp_sum          = $signed({2'b00, hp_level}) - dmg_term + heal_term;
        level_next      = hp_level;
        shown_next      = hp_shown;
        frame_cnt_next  = frame_cnt;
        state_next      = ST_IDLE;
        mem_health_next = '0;
        dead_next       = 1'b0;
        dead_pulse_next = 1'b0;

        // A dead player stays at zero regardless of events.
        if (hp_level == '0) begin
            level_next = '0;
        end else if (hp_sum < 7'sd0) begin
            level_next = '0;
        end else if (hp_sum > $signed(7'(MAX_HP))) begin
            level_next = HP_W'(MAX_HP);
        end else begin
            level_next = hp_sum[HP_W-1:0];
        end

        // Animation steps only on frame_start so the sprite never changes mid-frame.
        if (state == ST_IDLE) begin
            frame_cnt_next = '0;
        end else if (frame_start) begin
            if (frame_cnt == FCNT_W'(DRAIN_FRAMES - 1)) begin
                frame_cnt_next = '0;
                shown_next     = (state == ST_DRAIN) ? hp_shown - 5'd1 : hp_shown + 5'd1;
            end else begin
                frame_cnt_next = frame_cnt + FCNT_W'(1);
            end
        end

        if (game_reset) begin
            level_next     = HP_W'(MAX_HP);
            shown_next     = HP_W'(MAX_HP);
            frame_cnt_next = '0;
        end

        if (shown_next > level_next) begin
            state_next = ST_DRAIN;
        end else if (shown_next < level_next) begin
            state_next = ST_FILL;
        end

        mem_health_next = (shown_next == '0) ? 4'd0 : 4'(shown_next - 5'd1);
        dead_next       = (level_next == '0);
        dead_pulse_next = (hp_level != '0) && (level_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            frame_cnt  <= '0;
            hp_level   <= HP_W'(MAX_HP);
            hp_shown   <= HP_W'(MAX_HP);
            mem_health <= 4'(MAX_HP - 1);
            dead       <= 1'b0;
            dead_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            frame_cnt  <= frame_cnt_next;
            hp_level   <= level_next;
            hp_shown   <= shown_next;
            mem_health <= mem_health_next;
            dead       <= dead_next;
            dead_pulse <= dead_pulse_next;
        end
    end

    // Stage 1: window test and linear ROM address.
    always_comb begin
        dx     = pixel_x - 10'(BAR_X);
        dy     = pixel_y - 10'(BAR_Y);
        in_win = (pixel_x >= 10'(BAR_X)) && (pixel_x < 10'(BAR_X + BAR_W)) &&
                 (pixel_y >= 10'(BAR_Y)) && (pixel_y < 10'(BAR_Y + BAR_H));
    end

    logic in_win_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_win_q    <= 1'b0;
            mem_address <= '0;
            bar_active  <= 1'b0;
        end else if (game_reset) begin
            in_win_q    <= 1'b0;
            mem_address <= '0;
            bar_active  <= 1'b0;
        end else begin
            in_win_q    <= in_win;
            mem_address <= in_win ? 8'(dy * 10'(BAR_W) + dx) : 8'd0;
            bar_active  <= in_win_q;
        end
    end

`ifdef HEALTH_FLASH_EN
    localparam int unsigned FL_W = ($clog2(FLASH_FRAMES + 1) > 3) ? $clog2(FLASH_FRAMES + 1) : 3;

    logic [FL_W-1:0] flash_cnt;

    // Hit blink: reload on a real hit while alive, count down once per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt <= '0;
        end else if (game_reset) begin
            flash_cnt <= '0;
        end else if (dmg_valid && (dmg_amt != 4'd0) && (hp_level != '0)) begin
            flash_cnt <= FL_W'(FLASH_FRAMES);
        end else if (frame_start && (flash_cnt != '0)) begin
            flash_cnt <= flash_cnt - FL_W'(1);
        end
    end

    assign flash_mask = (flash_cnt != '0) && flash_cnt[2];
`else
    assign flash_mask = 1'b0;
`endif

    // Stage 2: ROM data arrives aligned with bar_active.
    assign bar_pixel = bar_active & mem_pixel & (hp_shown != '0) & ~flash_mask;

endmodule

// File: tb/tb_health_bar_controller.sv
// Self-checking bench for health_bar_controller with a registered-read sprite ROM model.
module tb_health_bar_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start, game_reset;
    logic       dmg_valid, heal_valid;
    logic [3:0] dmg_amt, heal_amt;
    logic [9:0] pixel_x, pixel_y;
    logic [3:0] mem_health;
    logic [7:0] mem_address;
    logic       mem_pixel = 1'b0;
    logic       bar_pixel, bar_active, dead, dead_pulse;
    logic [4:0] hp_level, hp_shown;

    int n_chk  = 0;
    int n_pass = 0;

    health_bar_controller dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .game_reset(game_reset),
        .dmg_valid(dmg_valid), .dmg_amt(dmg_amt), .heal_valid(heal_valid), .heal_amt(heal_amt),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .mem_health(mem_health), .mem_address(mem_address),
        .mem_pixel(mem_pixel), .bar_pixel(bar_pixel), .bar_active(bar_active),
        .hp_level(hp_level), .hp_shown(hp_shown), .dead(dead), .dead_pulse(dead_pulse)
    );

    always #5 clk = ~clk;

    // Sprite ROM: pixel set unless address is a multiple of (image+2).
    function automatic logic rom_bit(input logic [3:0] h, input logic [7:0] a);
        int ai;
        int hi;
        ai = int'(a);
        hi = int'(h);
        return (ai % (hi + 2)) != 0;
    endfunction

    always @(posedge clk) mem_pixel <= rom_bit(mem_health, mem_address);

    typedef struct {
        logic       dv;
        logic [3:0] da;
        logic       hv;
        logic [3:0] ha;
        int         hp;
        int         dd;
        int         dp;
    } hvec_t;

    typedef struct {
        int x;
        int y;
        int addr;
        int act;
        int pix;
    } pvec_t;

    hvec_t hv_tab[10];
    pvec_t pv_tab[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int flash_exp(input int c);
`ifdef HEALTH_FLASH_EN
        return ((c != 0) && (((c >> 2) & 1) == 1)) ? 0 : 1;
`else
        return (c >= 0) ? 1 : 1;
`endif
    endfunction

    initial begin
        hv_tab[0] = '{1'b1, 4'd3,  1'b0, 4'd0, 13, 0, 0};
        hv_tab[1] = '{1'b0, 4'd0,  1'b1, 4'd2, 15, 0, 0};
        hv_tab[2] = '{1'b0, 4'd0,  1'b1, 4'd5, 16, 0, 0};
        hv_tab[3] = '{1'b1, 4'd6,  1'b0, 4'd0, 10, 0, 0};
        hv_tab[4] = '{1'b1, 4'd5,  1'b1, 4'd2,  7, 0, 0};
        hv_tab[5] = '{1'b1, 4'd3,  1'b0, 4'd0,  4, 0, 0};
        hv_tab[6] = '{1'b1, 4'd15, 1'b0, 4'd0,  0, 1, 1};
        hv_tab[7] = '{1'b0, 4'd0,  1'b1, 4'd5,  0, 1, 0};
        hv_tab[8] = '{1'b1, 4'd1,  1'b0, 4'd0,  0, 1, 0};
        hv_tab[9] = '{1'b0, 4'd0,  1'b0, 4'd0,  0, 1, 0};

        pv_tab[0] = '{19, 10,  35, 1, 1};
        pv_tab[1] = '{18, 10,  34, 1, 0};
        pv_tab[2] = '{32,  8,   0, 0, 0};
        pv_tab[3] = '{31, 15, 127, 1, 1};
        pv_tab[4] = '{15,  8,   0, 0, 0};
        pv_tab[5] = '{16,  8,   0, 1, 0};

        rst_n = 1'b0; frame_start = 1'b0; game_reset = 1'b0;
        dmg_valid = 1'b0; dmg_amt = 4'd0; heal_valid = 1'b0; heal_amt = 4'd0;
        pixel_x = 10'd0; pixel_y = 10'd0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_hp_level", int'(hp_level), 16);
        chk("rst_hp_shown", int'(hp_shown), 16);
        chk("rst_mem_health", int'(mem_health), 15);
        chk("rst_dead", int'(dead), 0);
        chk("rst_bar_pixel", int'(bar_pixel), 0);

        // Pixel pipeline: address one cycle later, pixel/active two cycles later.
        foreach (pv_tab[i]) begin
            pixel_x = 10'(pv_tab[i].x);
            pixel_y = 10'(pv_tab[i].y);
            tick();
            chk($sformatf("pix%0d_addr", i), int'(mem_address), pv_tab[i].addr);
            tick();
            chk($sformatf("pix%0d_active", i), int'(bar_active), pv_tab[i].act);
            chk($sformatf("pix%0d_pixel", i), int'(bar_pixel), pv_tab[i].pix);
        end
        pixel_x = 10'd0; pixel_y = 10'd0;

        // Drain 16 -> 13, one step per four frames.
        dmg_valid = 1'b1; dmg_amt = 4'd3;
        tick();
        dmg_valid = 1'b0;
        chk("drain_level", int'(hp_level), 13);
        chk("drain_shown0", int'(hp_shown), 16);
        for (int k = 1; k <= 16; k++) begin
            int es;
            es = (k >= 12) ? 13 : 16 - k / 4;
            frame();
            chk($sformatf("drain_shown_f%0d", k), int'(hp_shown), es);
            chk($sformatf("drain_memh_f%0d", k), int'(mem_health), es - 1);
            tick();
        end

        // Fill 13 -> 15.
        heal_valid = 1'b1; heal_amt = 4'd2;
        tick();
        heal_valid = 1'b0;
        chk("fill_level", int'(hp_level), 15);
        for (int k = 1; k <= 8; k++) begin
            frame();
            if (k == 3) chk("fill_shown_f3", int'(hp_shown), 13);
            if (k == 4) chk("fill_shown_f4", int'(hp_shown), 14);
            if (k == 8) chk("fill_shown_f8", int'(hp_shown), 15);
            tick();
        end

        // Asynchronous reset in the middle of a drain.
        dmg_valid = 1'b1; dmg_amt = 4'd4;
        tick();
        dmg_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            frame();
            tick();
        end
        chk("mid_drain_shown", int'(hp_shown), 14);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_level", int'(hp_level), 16);
        chk("arst_shown", int'(hp_shown), 16);
        chk("arst_memh", int'(mem_health), 15);
        chk("arst_dead", int'(dead), 0);
        tick();
        rst_n = 1'b1;
        tick();
        dmg_valid = 1'b1; dmg_amt = 4'd1;
        tick();
        dmg_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            frame();
            chk($sformatf("post_arst_shown_f%0d", k), int'(hp_shown), (k == 4) ? 15 : 16);
            tick();
        end

        // Health arithmetic table from full health.
        game_reset = 1'b1;
        tick();
        game_reset = 1'b0;
        chk("gr_level", int'(hp_level), 16);
        chk("gr_shown", int'(hp_shown), 16);
        foreach (hv_tab[i]) begin
            dmg_valid  = hv_tab[i].dv; dmg_amt  = hv_tab[i].da;
            heal_valid = hv_tab[i].hv; heal_amt = hv_tab[i].ha;
            tick();
            dmg_valid = 1'b0; heal_valid = 1'b0;
            chk($sformatf("hv%0d_level", i), int'(hp_level), hv_tab[i].hp);
            chk($sformatf("hv%0d_dead", i), int'(dead), hv_tab[i].dd);
            chk($sformatf("hv%0d_pulse", i), int'(dead_pulse), hv_tab[i].dp);
        end

        // game_reset wins over simultaneous damage and revives.
        game_reset = 1'b1; dmg_valid = 1'b1; dmg_amt = 4'd8;
        tick();
        game_reset = 1'b0; dmg_valid = 1'b0;
        chk("revive_level", int'(hp_level), 16);
        chk("revive_shown", int'(hp_shown), 16);
        chk("revive_dead", int'(dead), 0);
        chk("revive_memh", int'(mem_health), 15);
        frame();
        chk("revive_idle_shown", int'(hp_shown), 16);

        // Hit blink: damage then immediate heal so the image stays constant.
        pixel_x = 10'd19; pixel_y = 10'd10;
        dmg_valid = 1'b1; dmg_amt = 4'd1;
        tick();
        dmg_valid = 1'b0; heal_valid = 1'b1; heal_amt = 4'd1;
        tick();
        heal_valid = 1'b0;
        tick(); tick();
        chk("flash_level", int'(hp_level), 16);
        for (int k = 0; k <= 35; k++) begin
            int c;
            c = (k > 32) ? 0 : 32 - k;
            chk($sformatf("flash_k%0d", k), int'(bar_pixel), flash_exp(c));
            frame();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
